// File: rtl/nexus_stream_tx_if.sv
// Request and inbound-stream bundle of nexus_stream_tx.
// Signal suffixes are relative to the transmitter: _i are driven by the host/mesh, _o by the transmitter.
interface nexus_stream_tx_if #(
   parameter int unsigned STREAM_WIDTH   = 32,
   parameter int unsigned ADDR_ROW_WIDTH = 4,
   parameter int unsigned ADDR_COL_WIDTH = 4,
   parameter int unsigned COMMAND_WIDTH  = 2,
   parameter int unsigned PAYLOAD_WIDTH  = STREAM_WIDTH - ADDR_ROW_WIDTH - ADDR_COL_WIDTH - COMMAND_WIDTH
);
   logic [ADDR_ROW_WIDTH-1:0] req_row_i;
   logic [ADDR_COL_WIDTH-1:0] req_col_i;
   logic [COMMAND_WIDTH-1:0]  req_command_i;
   logic [PAYLOAD_WIDTH-1:0]  req_payload_i;
   logic                      req_bcast_i;
   logic                      req_valid_i;
   logic                      req_ready_o;
   logic [STREAM_WIDTH-1:0]   inbound_data_o;
   logic                      inbound_valid_o;
   logic                      inbound_ready_i;

   modport master (
      output req_row_i, req_col_i, req_command_i, req_payload_i, req_bcast_i, req_valid_i,
      input  req_ready_o,
      input  inbound_data_o, inbound_valid_o,
      output inbound_ready_i
   );

   modport slave (
      input  req_row_i, req_col_i, req_command_i, req_payload_i, req_bcast_i, req_valid_i,
      output req_ready_o,
      output inbound_data_o, inbound_valid_o,
      input  inbound_ready_i
   );
endinterface

// File: rtl/nexus_stream_tx.sv
// Host-side transmitter: queues addressed/broadcast requests in a small FIFO and
// serialises them into packed inbound stream words, expanding broadcasts over the mesh.
module nexus_stream_tx #(
   parameter int unsigned ROWS           = 3,
   parameter int unsigned COLUMNS        = 3,
   parameter int unsigned STREAM_WIDTH   = 32,
   parameter int unsigned ADDR_ROW_WIDTH = 4,
   parameter int unsigned ADDR_COL_WIDTH = 4,
   parameter int unsigned COMMAND_WIDTH  = 2,
   parameter int unsigned PAYLOAD_WIDTH  = STREAM_WIDTH - ADDR_ROW_WIDTH - ADDR_COL_WIDTH - COMMAND_WIDTH,
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter int unsigned COUNTER_WIDTH  = 32
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   nexus_stream_tx_if.slave         bus,
   output logic                     busy_o,
   output logic [COUNTER_WIDTH-1:0] sent_count_o
);

   localparam int unsigned PTR_WIDTH   = $clog2(FIFO_DEPTH);
   localparam int unsigned CP_WIDTH    = COMMAND_WIDTH + PAYLOAD_WIDTH;
   localparam int unsigned ENTRY_WIDTH = 1 + STREAM_WIDTH;
   localparam logic [ADDR_ROW_WIDTH-1:0] ROW_LAST = ADDR_ROW_WIDTH'(ROWS - 1);
   localparam logic [ADDR_COL_WIDTH-1:0] COL_LAST = ADDR_COL_WIDTH'(COLUMNS - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_BCAST} state_t;

   logic [ENTRY_WIDTH-1:0]    fifo_q [FIFO_DEPTH];
   logic [PTR_WIDTH:0]        wr_ptr_q, wr_ptr_d;
   logic [PTR_WIDTH:0]        rd_ptr_q, rd_ptr_d;
   logic                      fifo_empty, fifo_full;
   logic                      push, pop;
   logic [ENTRY_WIDTH-1:0]    push_entry, head;

   state_t                    state_q, state_d;
   logic [ADDR_ROW_WIDTH-1:0] row_q, row_d;
   logic [ADDR_COL_WIDTH-1:0] col_q, col_d;
   logic [CP_WIDTH-1:0]       cp_q, cp_d;
   logic                      valid_q, valid_d;
   logic [COUNTER_WIDTH-1:0]  count_q, count_d;
   logic                      fire, bcast_last, load_next;

   // Ready depends only on occupancy, so a push into a full FIFO never rides on a same-cycle pop.
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[PTR_WIDTH] != rd_ptr_q[PTR_WIDTH]) &&
                       (wr_ptr_q[PTR_WIDTH-1:0] == rd_ptr_q[PTR_WIDTH-1:0]);
   assign push       = bus.req_valid_i & ~fifo_full;
   assign push_entry = {bus.req_bcast_i, bus.req_row_i, bus.req_col_i, bus.req_command_i, bus.req_payload_i};
   assign head       = fifo_q[rd_ptr_q[PTR_WIDTH-1:0]];
   assign wr_ptr_d   = push ? wr_ptr_q + (PTR_WIDTH+1)'(1) : wr_ptr_q;
   assign rd_ptr_d   = pop  ? rd_ptr_q + (PTR_WIDTH+1)'(1) : rd_ptr_q;

   assign fire       = valid_q & bus.inbound_ready_i;
   assign bcast_last = (row_q == ROW_LAST) && (col_q == COL_LAST);
   assign count_d    = fire ? count_q + COUNTER_WIDTH'(1) : count_q;

   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_q[wr_ptr_q[PTR_WIDTH-1:0]] <= push_entry;
      end
   end

   always_comb begin
      state_d   = state_q;
      row_d     = row_q;
      col_d     = col_q;
      cp_d      = cp_q;
      valid_d   = valid_q;
      pop       = 1'b0;
      load_next = 1'b0;
      case (state_q)
         ST_IDLE: load_next = 1'b1;
         ST_SEND: load_next = fire;
         ST_BCAST: begin
            if (fire) begin
               if (bcast_last) begin
                  load_next = 1'b1;
               end else if (col_q == COL_LAST) begin
                  col_d = '0;
                  row_d = row_q + ADDR_ROW_WIDTH'(1);
               end else begin
                  col_d = col_q + ADDR_COL_WIDTH'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Slot is free: refill from the FIFO head in the same cycle, or fall back to idle.
      if (load_next) begin
         if (!fifo_empty) begin
            pop     = 1'b1;
            valid_d = 1'b1;
            cp_d    = head[CP_WIDTH-1:0];
            if (head[STREAM_WIDTH]) begin
               row_d   = '0;
               col_d   = '0;
               state_d = ST_BCAST;
            end else begin
               row_d   = head[STREAM_WIDTH-1 -: ADDR_ROW_WIDTH];
               col_d   = head[STREAM_WIDTH-ADDR_ROW_WIDTH-1 -: ADDR_COL_WIDTH];
               state_d = ST_SEND;
            end
         end else begin
            valid_d = 1'b0;
            state_d = ST_IDLE;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         state_q  <= ST_IDLE;
         row_q    <= '0;
         col_q    <= '0;
         cp_q     <= '0;
         valid_q  <= 1'b0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         state_q  <= state_d;
         row_q    <= row_d;
         col_q    <= col_d;
         cp_q     <= cp_d;
         valid_q  <= valid_d;
         count_q  <= count_d;
      end
   end

   assign bus.req_ready_o     = ~fifo_full;
   assign bus.inbound_data_o  = {row_q, col_q, cp_q};
   assign bus.inbound_valid_o = valid_q;
   assign busy_o              = ~fifo_empty | valid_q;
   assign sent_count_o        = count_q;

endmodule

// File: tb/tb_nexus_stream_tx.sv
// Directed bench for nexus_stream_tx: cycle table for basic traffic, then hand sequences
// for broadcast, backpressure, FIFO full, reset abort and counter wrap (4-bit twin DUT).
module tb_nexus_stream_tx;

   logic        clk = 1'b0;
   logic        rst;
   logic        busy, busy4;
   logic [31:0] cnt;
   logic [3:0]  cnt4;
   int          n_checks = 0;
   int          n_fail   = 0;
   logic        mon_en   = 1'b0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   nexus_stream_tx_if bus ();
   nexus_stream_tx_if bus4 ();

   // Twin DUT sees the same stimulus; only its counter width differs.
   assign bus4.req_row_i       = bus.req_row_i;
   assign bus4.req_col_i       = bus.req_col_i;
   assign bus4.req_command_i   = bus.req_command_i;
   assign bus4.req_payload_i   = bus.req_payload_i;
   assign bus4.req_bcast_i     = bus.req_bcast_i;
   assign bus4.req_valid_i     = bus.req_valid_i;
   assign bus4.inbound_ready_i = bus.inbound_ready_i;

   nexus_stream_tx #(.ROWS(3), .COLUMNS(3), .FIFO_DEPTH(4), .COUNTER_WIDTH(32)) dut (
      .clk_i(clk), .rst_i(rst), .bus(bus), .busy_o(busy), .sent_count_o(cnt));

   nexus_stream_tx #(.ROWS(3), .COLUMNS(3), .FIFO_DEPTH(4), .COUNTER_WIDTH(4)) dut4 (
      .clk_i(clk), .rst_i(rst), .bus(bus4), .busy_o(busy4), .sent_count_o(cnt4));

   typedef struct {
      logic        vld;
      logic [3:0]  row;
      logic [3:0]  col;
      logic [1:0]  cmd;
      logic [21:0] pay;
      logic        rdy;
      logic        e_rrdy;
      logic        e_vld;
      logic        e_busy;
      logic [31:0] e_data;
      logic [31:0] e_cnt;
   } vec_t;

   vec_t tbl [12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] pack(input int r, input int c, input int cm, input logic [21:0] p);
      return {4'(r), 4'(c), 2'(cm), p};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Acceptance is decided by req_ready before the edge; ready depends on state only.
   task automatic push(input logic bc, input logic [3:0] r, input logic [3:0] c,
                       input logic [1:0] cm, input logic [21:0] p);
      logic acc;
      int   g;
      bus.req_bcast_i   = bc;
      bus.req_row_i     = r;
      bus.req_col_i     = c;
      bus.req_command_i = cm;
      bus.req_payload_i = p;
      bus.req_valid_i   = 1'b1;
      g = 0;
      do begin
         acc = bus.req_ready_o;
         tick();
         g++;
      end while (!acc && g < 100);
      bus.req_valid_i = 1'b0;
      check("push_accepted", acc, 1'b1);
   endtask

   task automatic drain(input string name);
      int g;
      g = 0;
      while ((busy || bus.inbound_valid_o) && g < 200) begin
         tick();
         g++;
      end
      check({name, "_idle"}, busy, 1'b0);
      check({name, "_all_beats_seen"}, exp_q.size(), 0);
   endtask

   // Beat scoreboard: sampled mid-cycle, so valid/ready are what the next edge will see.
   always @(negedge clk) begin
      if (mon_en && !rst && bus.inbound_valid_o && bus.inbound_ready_i) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_beat: got %h, expected no beat", bus.inbound_data_o);
         end else begin
            check("beat_order", bus.inbound_data_o, exp_q.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] base;
      logic [31:0] held;
      int          g;

      tbl[0]  = '{1'b1, 4'd2,  4'd1,  2'd1, 22'h12345,  1'b1, 1'b1, 1'b0, 1'b1, 32'h00000000, 32'd0};
      tbl[1]  = '{1'b0, 4'd0,  4'd0,  2'd0, 22'h0,      1'b1, 1'b1, 1'b1, 1'b1, 32'h21412345, 32'd0};
      tbl[2]  = '{1'b0, 4'd0,  4'd0,  2'd0, 22'h0,      1'b1, 1'b1, 1'b0, 1'b0, 32'h21412345, 32'd1};
      tbl[3]  = '{1'b1, 4'd1,  4'd0,  2'd3, 22'h000AA,  1'b1, 1'b1, 1'b0, 1'b1, 32'h21412345, 32'd1};
      tbl[4]  = '{1'b1, 4'd0,  4'd2,  2'd0, 22'h3FFFFF, 1'b1, 1'b1, 1'b1, 1'b1, 32'h10C000AA, 32'd1};
      tbl[5]  = '{1'b0, 4'd0,  4'd0,  2'd0, 22'h0,      1'b1, 1'b1, 1'b1, 1'b1, 32'h023FFFFF, 32'd2};
      tbl[6]  = '{1'b0, 4'd0,  4'd0,  2'd0, 22'h0,      1'b1, 1'b1, 1'b0, 1'b0, 32'h023FFFFF, 32'd3};
      tbl[7]  = '{1'b0, 4'd0,  4'd0,  2'd0, 22'h0,      1'b1, 1'b1, 1'b0, 1'b0, 32'h023FFFFF, 32'd3};
      tbl[8]  = '{1'b1, 4'd15, 4'd15, 2'd3, 22'h0,      1'b0, 1'b1, 1'b0, 1'b1, 32'h023FFFFF, 32'd3};
      tbl[9]  = '{1'b0, 4'd0,  4'd0,  2'd0, 22'h0,      1'b0, 1'b1, 1'b1, 1'b1, 32'hFFC00000, 32'd3};
      tbl[10] = '{1'b0, 4'd0,  4'd0,  2'd0, 22'h0,      1'b0, 1'b1, 1'b1, 1'b1, 32'hFFC00000, 32'd3};
      tbl[11] = '{1'b0, 4'd0,  4'd0,  2'd0, 22'h0,      1'b1, 1'b1, 1'b0, 1'b0, 32'hFFC00000, 32'd4};

      rst = 1'b1;
      bus.req_row_i = '0; bus.req_col_i = '0; bus.req_command_i = '0; bus.req_payload_i = '0;
      bus.req_bcast_i = 1'b0; bus.req_valid_i = 1'b0; bus.inbound_ready_i = 1'b0;
      #2;
      check("rst_valid", bus.inbound_valid_o, 1'b0);
      check("rst_data", bus.inbound_data_o, 32'h0);
      check("rst_count", cnt, 32'h0);
      check("rst_busy", busy, 1'b0);
      tick();
      tick();
      rst = 1'b0;
      check("post_rst_req_ready", bus.req_ready_o, 1'b1);

      for (int i = 0; i < 12; i++) begin
         bus.req_valid_i   = tbl[i].vld;
         bus.req_bcast_i   = 1'b0;
         bus.req_row_i     = tbl[i].row;
         bus.req_col_i     = tbl[i].col;
         bus.req_command_i = tbl[i].cmd;
         bus.req_payload_i = tbl[i].pay;
         bus.inbound_ready_i = tbl[i].rdy;
         tick();
         check($sformatf("vec%0d_req_ready", i), bus.req_ready_o, tbl[i].e_rrdy);
         check($sformatf("vec%0d_valid", i), bus.inbound_valid_o, tbl[i].e_vld);
         check($sformatf("vec%0d_busy", i), busy, tbl[i].e_busy);
         check($sformatf("vec%0d_data", i), bus.inbound_data_o, tbl[i].e_data);
         check($sformatf("vec%0d_count", i), cnt, tbl[i].e_cnt);
      end
      bus.req_valid_i = 1'b0;

      // Broadcast followed by a single request: ten beats on ten consecutive cycles.
      mon_en = 1'b1;
      bus.inbound_ready_i = 1'b1;
      base = cnt;
      for (int k = 0; k < 9; k++) exp_q.push_back(pack(k / 3, k % 3, 2, 22'h3));
      exp_q.push_back(pack(1, 1, 1, 22'h55));
      push(1'b1, 4'd5, 4'd7, 2'd2, 22'h3);
      push(1'b0, 4'd1, 4'd1, 2'd1, 22'h55);
      g = 0;
      while (!bus.inbound_valid_o && g < 20) begin tick(); g++; end
      for (int k = 0; k < 10; k++) begin
         check($sformatf("bcast_stream_beat%0d_valid", k), bus.inbound_valid_o, 1'b1);
         tick();
      end
      check("bcast_end_valid", bus.inbound_valid_o, 1'b0);
      check("bcast_count", cnt, base + 32'd10);
      drain("bcast");

      // Backpressure mid-stream: the second of three requests is held for five cycles.
      base = cnt;
      exp_q.push_back(pack(3, 2, 1, 22'h111));
      exp_q.push_back(pack(0, 1, 2, 22'h2222));
      exp_q.push_back(pack(2, 0, 3, 22'h3));
      push(1'b0, 4'd3, 4'd2, 2'd1, 22'h111);
      push(1'b0, 4'd0, 4'd1, 2'd2, 22'h2222);
      push(1'b0, 4'd2, 4'd0, 2'd3, 22'h3);
      bus.inbound_ready_i = 1'b0;
      held = pack(0, 1, 2, 22'h2222);
      check("bp_held_data", bus.inbound_data_o, held);
      for (int k = 0; k < 5; k++) begin
         tick();
         check($sformatf("bp_stall%0d_valid", k), bus.inbound_valid_o, 1'b1);
         check($sformatf("bp_stall%0d_data", k), bus.inbound_data_o, held);
         check($sformatf("bp_stall%0d_count", k), cnt, base + 32'd1);
      end
      bus.inbound_ready_i = 1'b1;
      drain("bp");
      check("bp_count", cnt, base + 32'd3);

      // FIFO full: slot holds request 0, FIFO holds 1..4, request 5 waits for a pop.
      base = cnt;
      bus.inbound_ready_i = 1'b0;
      for (int i = 0; i < 6; i++) exp_q.push_back(pack(i, i, i % 4, 22'h100 + 22'(i)));
      for (int i = 0; i < 5; i++) begin
         push(1'b0, 4'(i), 4'(i), 2'(i % 4), 22'h100 + 22'(i));
         check($sformatf("full_push%0d_req_ready", i), bus.req_ready_o, (i < 4) ? 1'b1 : 1'b0);
      end
      bus.req_row_i = 4'd5; bus.req_col_i = 4'd5; bus.req_command_i = 2'd1;
      bus.req_payload_i = 22'h105; bus.req_bcast_i = 1'b0; bus.req_valid_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check($sformatf("full_hold%0d_req_ready", k), bus.req_ready_o, 1'b0);
      end
      bus.inbound_ready_i = 1'b1;
      tick();
      check("full_after_pop_req_ready", bus.req_ready_o, 1'b1);
      tick();
      bus.req_valid_i = 1'b0;
      drain("full");
      check("full_count", cnt, base + 32'd6);

      // Reset mid-broadcast after four beats with two requests queued.
      base = cnt;
      for (int k = 0; k < 4; k++) exp_q.push_back(pack(k / 3, k % 3, 1, 22'h7));
      push(1'b1, 4'd0, 4'd0, 2'd1, 22'h7);
      push(1'b0, 4'd1, 4'd2, 2'd0, 22'h8);
      push(1'b0, 4'd2, 4'd1, 2'd0, 22'h9);
      g = 0;
      while (cnt != base + 32'd4 && g < 50) begin tick(); g++; end
      check("rst_mid_beats_before", cnt, base + 32'd4);
      check("rst_mid_busy_before", busy, 1'b1);
      rst = 1'b1;
      #1;
      check("rst_mid_valid", bus.inbound_valid_o, 1'b0);
      check("rst_mid_data", bus.inbound_data_o, 32'h0);
      check("rst_mid_count", cnt, 32'h0);
      check("rst_mid_busy", busy, 1'b0);
      exp_q.delete();
      tick();
      rst = 1'b0;
      for (int k = 0; k < 20; k++) tick();
      check("rst_after_valid", bus.inbound_valid_o, 1'b0);
      check("rst_after_count", cnt, 32'h0);
      check("rst_after_busy", busy, 1'b0);
      check("rst_after_req_ready", bus.req_ready_o, 1'b1);

      // Counter wrap: 17 beats from reset leave the 4-bit counter at 1.
      for (int k = 0; k < 9; k++) exp_q.push_back(pack(k / 3, k % 3, 3, 22'h1));
      for (int i = 0; i < 8; i++) exp_q.push_back(pack(i % 3, 2, 0, 22'h200 + 22'(i)));
      push(1'b1, 4'd0, 4'd0, 2'd3, 22'h1);
      for (int i = 0; i < 8; i++) push(1'b0, 4'(i % 3), 4'd2, 2'd0, 22'h200 + 22'(i));
      drain("wrap");
      check("wrap_count32", cnt, 32'd17);
      check("wrap_count4", 32'(cnt4), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
